// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, fault cause codes and the
// NOP word the instruction register resets to.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_e;

  localparam logic [1:0]  FAULT_NONE     = 2'b00;
  localparam logic [1:0]  FAULT_MISALIGN = 2'b01;
  localparam logic [1:0]  FAULT_TIMEOUT  = 2'b10;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

endpackage

// File: rtl/fetch_timeout_counter.sv
// WAIT-cycle watchdog: loads TIMEOUT_CYCLES-1 on clear, counts down while enabled,
// and flags terminal count on the last permitted WAIT cycle.
module fetch_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc
);

  localparam logic [7:0] LOAD_VAL = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = LOAD_VAL;
    end else if (i_en && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= LOAD_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_tc = i_en && (count_q == 8'd0);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding word read per PC, instruction held for decode under
// a valid/taken handshake. Bus-timeout fault exists only with INSTR_FETCH_TIMEOUT_EN.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int RESET_PC_CHECK = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_PC,
  input  logic            i_flush,
  output logic [XLEN-1:0] o_mem_addr,
  output logic            o_mem_req,
  input  logic            i_mem_DV,
  input  logic [XLEN-1:0] i_mem_data,
  output logic [XLEN-1:0] o_instr,
  output logic            o_instr_DV,
  input  logic            i_instr_taken,
  output logic            o_fault,
  output logic [1:0]      o_fault_cause
);

  // state | meaning
  // IDLE  | post-reset, moves to REQ next edge
  // REQ   | sample PC, launch read (or fault on misalignment)
  // WAIT  | read outstanding, waiting for i_mem_DV
  // HOLD  | instruction valid for decode
  // FAULT | terminal until reset

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic            mem_req_q, mem_req_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            instr_dv_q, instr_dv_d;
  logic            fault_q, fault_d;
  logic [1:0]      cause_q, cause_d;
  logic            flush_pending_q, flush_pending_d;
  logic            timeout_hit;

`ifdef INSTR_FETCH_TIMEOUT_EN
  fetch_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (state_q == ST_WAIT),
    .i_clr (state_q == ST_REQ),
    .o_tc  (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    mem_addr_d      = mem_addr_q;
    mem_req_d       = 1'b0;
    instr_d         = instr_q;
    instr_dv_d      = instr_dv_q;
    fault_d         = fault_q;
    cause_d         = cause_q;
    flush_pending_d = flush_pending_q;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if ((RESET_PC_CHECK != 0) && (i_PC[1:0] != 2'b00)) begin
          fault_d = 1'b1;
          cause_d = FAULT_MISALIGN;
          state_d = ST_FAULT;
        end else begin
          mem_addr_d      = {i_PC[XLEN-1:2], 2'b00};
          mem_req_d       = 1'b1;
          flush_pending_d = 1'b0;
          state_d         = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A flush cannot cancel the bus read, so the data is absorbed and dropped.
        if (i_mem_DV) begin
          flush_pending_d = 1'b0;
          if (flush_pending_q || i_flush) begin
            state_d = ST_REQ;
          end else begin
            instr_d    = i_mem_data;
            instr_dv_d = 1'b1;
            state_d    = ST_HOLD;
          end
        end else if (timeout_hit) begin
          fault_d = 1'b1;
          cause_d = FAULT_TIMEOUT;
          state_d = ST_FAULT;
        end else if (i_flush) begin
          flush_pending_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (i_flush || i_instr_taken) begin
          instr_dv_d = 1'b0;
          state_d    = ST_REQ;
        end
      end
      ST_FAULT: instr_dv_d = 1'b0;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q         <= ST_IDLE;
      mem_addr_q      <= '0;
      mem_req_q       <= 1'b0;
      instr_q         <= XLEN'(NOP_INSTR);
      instr_dv_q      <= 1'b0;
      fault_q         <= 1'b0;
      cause_q         <= FAULT_NONE;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      mem_addr_q      <= mem_addr_d;
      mem_req_q       <= mem_req_d;
      instr_q         <= instr_d;
      instr_dv_q      <= instr_dv_d;
      fault_q         <= fault_d;
      cause_q         <= cause_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  assign o_mem_addr    = mem_addr_q;
  assign o_mem_req     = mem_req_q;
  assign o_instr       = instr_q;
  assign o_instr_DV    = instr_dv_q;
  assign o_fault       = fault_q;
  assign o_fault_cause = cause_q;

endmodule
